// File: rtl/gpio_pkg.sv
// Shared helpers for the GPIO port: per-bit read-back selection.
package gpio_pkg;

  // Output bits read back their own latch; input bits read the pin.
  function automatic logic rd_bit(input logic dir_bit, input logic latch_bit,
                                  input logic pin_bit);
    return dir_bit ? latch_bit : pin_bit;
  endfunction

endpackage

// File: rtl/gpio.sv
// Bidirectional GPIO port: registered output latch, per-bit tristate drive and read-back.
// Latch updates one cycle after a write; pin drive and dout are combinational, no backpressure.
module gpio
  import gpio_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] dir,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  inout  wire  [WIDTH-1:0] io
);

  logic [WIDTH-1:0] latch_q;
  logic [WIDTH-1:0] latch_d;

  // Writes land regardless of dir so a value can be staged before enabling drive.
  always_comb begin
    latch_d = latch_q;
    if (we) latch_d = din;
  end

  always_ff @(posedge clk) begin
    if (reset) latch_q <= '0;
    else       latch_q <= latch_d;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign io[i]   = dir[i] ? latch_q[i] : 1'bz;
    assign dout[i] = rd_bit(dir[i], latch_q[i], io[i]);
  end

endmodule

// File: tb/tb_gpio.sv
// Scoreboard bench for gpio (WIDTH=8): directed cases then randomized cycles vs. a bit-level model.
module tb_gpio;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         we = 1'b0;
  logic [W-1:0] dir = '0;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;
  wire  [W-1:0] io;
  logic [W-1:0] tb_en = '0;
  logic [W-1:0] tb_val = '0;

  always #5 clk = ~clk;

  gpio #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .dir  (dir),
    .din  (din),
    .dout (dout),
    .io   (io)
  );

  // External pin drivers standing in for the board.
  for (genvar i = 0; i < W; i++) begin : g_ext
    assign io[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  typedef struct {
    string        name;
    logic [W-1:0] exp_dout;
    logic [W-1:0] exp_io;
    logic [W-1:0] mask;
  } exp_t;

  exp_t q[$];
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  // Reference model: the latch as a plain number, known only after the first reset.
  int unsigned m_latch = 0;
  bit          m_known = 0;

  task automatic apply(input string nm, input logic r, input logic w,
                       input logic [W-1:0] d, input logic [W-1:0] di,
                       input logic [W-1:0] en, input logic [W-1:0] val);
    exp_t e;
    reset  = r;
    we     = w;
    dir    = d;
    din    = di;
    tb_en  = en & ~d;
    tb_val = val;
    if (m_known) begin
      e.name = nm;
      e.exp_dout = '0;
      e.exp_io = '0;
      e.mask = '0;
      for (int b = 0; b < W; b++) begin
        if (d[b]) begin
          e.exp_dout[b] = ((m_latch >> b) & 1) != 0;
          e.exp_io[b]   = e.exp_dout[b];
          e.mask[b]     = 1'b1;
        end else if (en[b]) begin
          e.exp_dout[b] = val[b];
          e.exp_io[b]   = val[b];
          e.mask[b]     = 1'b1;
        end
      end
      q.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      m_latch = 0;
      m_known = 1;
    end else if (w) begin
      m_latch = int'(di);
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk_cnt++;
      if ((dout & e.mask) === (e.exp_dout & e.mask)) pass_cnt++;
      else $display("FAIL %s dout: got %h want %h (mask %h)", e.name, dout, e.exp_dout, e.mask);
      chk_cnt++;
      if ((io & e.mask) === (e.exp_io & e.mask)) pass_cnt++;
      else $display("FAIL %s io: got %h want %h (mask %h)", e.name, io, e.exp_io, e.mask);
    end
  end

  initial begin
    logic [W-1:0] rd, rdi, ren, rval;
    logic         rr, rw;
    #1;
    apply("reset",         1, 0, 8'hFF, 8'h00, 8'h00, 8'h00);
    apply("after_reset",   0, 0, 8'hFF, 8'h00, 8'h00, 8'h00);
    apply("write_a5",      0, 1, 8'hFF, 8'hA5, 8'h00, 8'h00);
    apply("hold_a5",       0, 0, 8'hFF, 8'h3C, 8'h00, 8'h00);
    apply("hold_a5_again", 0, 0, 8'hFF, 8'h3C, 8'h00, 8'h00);
    apply("input_5a",      0, 0, 8'h00, 8'h00, 8'hFF, 8'h5A);
    apply("write_33",      0, 1, 8'hFF, 8'h33, 8'h00, 8'h00);
    apply("mixed_0f",      0, 0, 8'h0F, 8'h00, 8'hF0, 8'hC0);
    apply("preload_81",    0, 1, 8'h00, 8'h81, 8'hFF, 8'h00);
    apply("enable_81",     0, 0, 8'hFF, 8'h00, 8'h00, 8'h00);
    apply("reset_vs_we",   1, 1, 8'hFF, 8'hFF, 8'h00, 8'h00);
    apply("after_rst_we",  0, 0, 8'hFF, 8'h00, 8'h00, 8'h00);
    for (int n = 0; n < 300; n++) begin
      rr   = ($urandom_range(0, 15) == 0);
      rw   = $urandom_range(0, 1) == 1;
      rd   = W'($urandom);
      rdi  = W'($urandom);
      ren  = W'($urandom) | W'($urandom);
      rval = W'($urandom);
      apply("random", rr, rw, rd, rdi, ren, rval);
    end
    @(negedge clk);
    @(negedge clk);
    chk_cnt++;
    if (q.size() == 0) pass_cnt++;
    else $display("FAIL drain: got %0d pending want 0", q.size());
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
